ptp_event_gen: RTL and testbench

Transmit-side counterpart of the TSU PTP parser: builds complete Layer-2 PTPv2 event frames (Sync or Delay_Req, EtherType 0x88F7) on the 32-bit packet stream interface (data/valid/sop/eop/mod) with sink backpressure. It latches RTC time when the SOP word is accepted, writes that time into originTimestamp, and reports {seqid, msgid, sop_time} in the same 52-bit format the parser reports on receive. The block sits between the RTC/control logic and the MAC transmit path.

---
 rtl/ptp_pkg.sv | 26 ++
 rtl/ptp_word_mux.sv | 54 +++++
 rtl/ptp_event_gen.sv | 136 +++++++++++++
 tb/tb_ptp_event_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_pkg.sv
// Shared PTP constants, message IDs, generator FSM states and per-message field helpers.
package ptp_pkg;

   localparam logic [15:0] ETH_PTP  = 16'h88F7;
   localparam logic [15:0] ETH_VLAN = 16'h8100;
   localparam logic [3:0]  PTP_VER  = 4'h2;
   localparam logic [15:0] PTP_LEN  = 16'd44;

   localparam logic [3:0]  MSG_SYNC = 4'd0;
   localparam logic [3:0]  MSG_DREQ = 4'd1;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Sync is sent two-step, so its follow-up carries the precise time.
   function automatic logic [15:0] msg_flags(input logic [3:0] msgid);
      return (msgid == MSG_SYNC) ? 16'h0200 : 16'h0000;
   endfunction

   function automatic logic [7:0] msg_control(input logic [3:0] msgid);
      return (msgid == MSG_SYNC) ? 8'h00 : 8'h01;
   endfunction

endpackage

// File: rtl/ptp_word_mux.sv
// Combinational word table for the generated PTP event frame; index -> 32-bit big-endian word.
// PTP_GEN_VLAN_EN inserts an 802.1Q tag as word 3 and shifts the remaining words by one.
module ptp_word_mux
   import ptp_pkg::*;
#(
   parameter logic [47:0] DST_MAC       = 48'h011B19000000,
   parameter logic [47:0] SRC_MAC       = 48'h000000000000,
   parameter logic [63:0] CLOCK_ID      = 64'h0,
   parameter logic [15:0] PORT_NUM      = 16'd1,
   parameter logic [7:0]  DOMAIN        = 8'd0,
   parameter logic [7:0]  LOG_SYNC_INTV = 8'h00,
   parameter logic [15:0] VLAN_TCI      = 16'h0000
) (
   input  logic [3:0]  idx,
   input  logic [3:0]  msgid,
   input  logic [15:0] seqid,
   input  logic [47:0] sec,
   input  logic [31:0] ns,
   output logic [31:0] word
);

   logic [3:0]  pidx;
   logic [7:0]  log_intv;

   always_comb begin
      log_intv = (msgid == MSG_SYNC) ? LOG_SYNC_INTV : 8'h7F;
`ifdef PTP_GEN_VLAN_EN
      pidx = (idx > 4'd3) ? idx - 4'd1 : idx;
`else
      pidx = idx;
`endif
      word = '0;
      case (pidx)
         4'd0:    word = DST_MAC[47:16];
         4'd1:    word = {DST_MAC[15:0], SRC_MAC[47:32]};
         4'd2:    word = SRC_MAC[31:0];
         4'd3:    word = {ETH_PTP, 4'h0, msgid, 4'h0, PTP_VER};
         4'd4:    word = {PTP_LEN, DOMAIN, 8'h00};
         4'd5:    word = {msg_flags(msgid), 16'h0000};
         4'd8:    word = {16'h0000, CLOCK_ID[63:48]};
         4'd9:    word = CLOCK_ID[47:16];
         4'd10:   word = {CLOCK_ID[15:0], PORT_NUM};
         4'd11:   word = {seqid, msg_control(msgid), log_intv};
         4'd12:   word = sec[47:16];
         4'd13:   word = {sec[15:0], ns[31:16]};
         4'd14:   word = {ns[15:0], 16'h0000};
         default: word = '0;
      endcase
`ifdef PTP_GEN_VLAN_EN
      if (idx == 4'd3) word = {ETH_VLAN, VLAN_TCI};
`endif
   end

endmodule

// File: rtl/ptp_event_gen.sv
// PTPv2 Layer-2 event frame generator (Sync / Delay_Req) on a 32-bit packet stream.
// Define PTP_GEN_VLAN_EN to emit 802.1Q-tagged 16-word frames instead of 15-word untagged ones.
module ptp_event_gen
   import ptp_pkg::*;
#(
   parameter logic [47:0] DST_MAC       = 48'h011B19000000,
   parameter logic [47:0] SRC_MAC       = 48'h000000000000,
   parameter logic [63:0] CLOCK_ID      = 64'h0,
   parameter logic [15:0] PORT_NUM      = 16'd1,
   parameter logic [7:0]  DOMAIN        = 8'd0,
   parameter logic [7:0]  LOG_SYNC_INTV = 8'h00,
   parameter logic [15:0] VLAN_TCI      = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_req,
   input  logic        tx_type,
   input  logic [15:0] tx_seqid,
   input  logic [47:0] rtc_sec,
   input  logic [31:0] rtc_ns,
   output logic        tx_ack,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   output logic        tx_sop,
   output logic        tx_eop,
   output logic [1:0]  tx_mod,
   input  logic        tx_ready,
   output logic        tx_done,
   output logic [51:0] tx_infor
);

`ifdef PTP_GEN_VLAN_EN
   localparam logic [3:0] LAST = 4'd15;
`else
   localparam logic [3:0] LAST = 4'd14;
`endif

   state_t      state;
   logic [3:0]  wcnt;
   logic [3:0]  msgid_q;
   logic [15:0] seqid_q;
   logic [47:0] sec_q;
   logic [31:0] ns_q;
   logic [3:0]  nxt_idx;
   logic [31:0] nxt_word;
   logic        xfer;
   logic        accept;
   logic        sop_xfer;

   assign xfer     = tx_valid && tx_ready;
   assign accept   = (state == IDLE) && tx_req;
   assign sop_xfer = (state == SEND) && xfer && (wcnt == 4'd0);
   // The output register always loads the word that will be on the bus next.
   assign nxt_idx  = (state == IDLE) ? 4'd0 : wcnt + 4'd1;
   assign tx_mod   = 2'b00;

   ptp_word_mux #(
      .DST_MAC      (DST_MAC),
      .SRC_MAC      (SRC_MAC),
      .CLOCK_ID     (CLOCK_ID),
      .PORT_NUM     (PORT_NUM),
      .DOMAIN       (DOMAIN),
      .LOG_SYNC_INTV(LOG_SYNC_INTV),
      .VLAN_TCI     (VLAN_TCI)
   ) u_word_mux (
      .idx  (nxt_idx),
      .msgid(msgid_q),
      .seqid(seqid_q),
      .sec  (sec_q),
      .ns   (ns_q),
      .word (nxt_word)
   );

   // Request fields and SOP timestamp: data only, no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         msgid_q <= tx_type ? MSG_DREQ : MSG_SYNC;
         seqid_q <= tx_seqid;
      end
      if (sop_xfer) begin
         sec_q <= rtc_sec;
         ns_q  <= rtc_ns;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wcnt     <= 4'd0;
         tx_ack   <= 1'b0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         tx_sop   <= 1'b0;
         tx_eop   <= 1'b0;
         tx_done  <= 1'b0;
         tx_infor <= '0;
      end else begin
         tx_ack   <= 1'b0;
         tx_done  <= 1'b0;
         tx_infor <= '0;
         case (state)
            IDLE: begin
               if (tx_req) begin
                  tx_ack   <= 1'b1;
                  wcnt     <= 4'd0;
                  state    <= SEND;
                  tx_valid <= 1'b1;
                  tx_sop   <= 1'b1;
                  tx_eop   <= 1'b0;
                  tx_data  <= nxt_word;
               end
            end
            SEND: begin
               if (xfer) begin
                  if (wcnt == LAST) begin
                     state    <= IDLE;
                     tx_valid <= 1'b0;
                     tx_sop   <= 1'b0;
                     tx_eop   <= 1'b0;
                     tx_data  <= '0;
                     tx_done  <= 1'b1;
                     tx_infor <= {seqid_q, msgid_q, ns_q};
                  end else begin
                     wcnt    <= nxt_idx;
                     tx_sop  <= 1'b0;
                     tx_eop  <= (nxt_idx == LAST);
                     tx_data <= nxt_word;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ptp_event_gen.sv
// Randomized self-checking bench for ptp_event_gen against a byte-level frame model.
module tb_ptp_event_gen;

   localparam logic [47:0] T_DST  = 48'h011B19000000;
   localparam logic [47:0] T_SRC  = 48'h0A1B2C3D4E5F;
   localparam logic [63:0] T_CID  = 64'h0011223344556677;
   localparam logic [15:0] T_PORT = 16'h0003;
   localparam logic [7:0]  T_DOM  = 8'h05;
   localparam logic [7:0]  T_LOGI = 8'hFD;
   localparam logic [15:0] T_TCI  = 16'hA00B;
`ifdef PTP_GEN_VLAN_EN
   localparam int NW = 16;
`else
   localparam int NW = 15;
`endif
   localparam int OFF = NW - 15;

   logic        clk = 1'b0;
   logic        rst_n, tx_req, tx_type, tx_ready;
   logic [15:0] tx_seqid;
   logic [47:0] rtc_sec;
   logic [31:0] rtc_ns;
   logic        tx_ack, tx_valid, tx_sop, tx_eop, tx_done;
   logic [31:0] tx_data;
   logic [1:0]  tx_mod;
   logic [51:0] tx_infor;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] exp_words [16];
   logic [31:0] cap_words [16];
   int          cap_n, hold_err, flag_err;
   bit          cap_timeout, rtc_inc;
   logic [47:0] cap_sec;
   logic [31:0] cap_ns;
   logic        cap_done, cap_valid_after;
   logic [51:0] cap_infor;

   always #5 clk = ~clk;

   ptp_event_gen #(
      .DST_MAC(T_DST), .SRC_MAC(T_SRC), .CLOCK_ID(T_CID), .PORT_NUM(T_PORT),
      .DOMAIN(T_DOM), .LOG_SYNC_INTV(T_LOGI), .VLAN_TCI(T_TCI)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .tx_type(tx_type), .tx_seqid(tx_seqid),
      .rtc_sec(rtc_sec), .rtc_ns(rtc_ns), .tx_ack(tx_ack), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_mod(tx_mod),
      .tx_ready(tx_ready), .tx_done(tx_done), .tx_infor(tx_infor)
   );

   // Reference frame built as a byte sequence (Ethernet header + PTP header + body), then packed.
   function automatic void build_frame(input logic typ, input logic [15:0] seq,
                                       input logic [47:0] sec, input logic [31:0] ns);
      logic [7:0]  b [64];
      logic [15:0] flg;
      int n;
      for (int i = 0; i < 64; i++) b[i] = 8'h00;
      n = 0;
      for (int i = 5; i >= 0; i--) begin b[n] = T_DST[i*8 +: 8]; n++; end
      for (int i = 5; i >= 0; i--) begin b[n] = T_SRC[i*8 +: 8]; n++; end
`ifdef PTP_GEN_VLAN_EN
      b[n] = 8'h81; b[n+1] = 8'h00; b[n+2] = T_TCI[15:8]; b[n+3] = T_TCI[7:0]; n += 4;
`endif
      b[n] = 8'h88; b[n+1] = 8'hF7; n += 2;
      b[n] = {7'd0, typ}; b[n+1] = 8'h02; b[n+2] = 8'h00; b[n+3] = 8'd44;
      b[n+4] = T_DOM; b[n+5] = 8'h00; n += 6;
      flg = typ ? 16'h0000 : 16'h0200;
      b[n] = flg[15:8]; b[n+1] = flg[7:0]; n += 2;
      n += 12;
      for (int i = 7; i >= 0; i--) begin b[n] = T_CID[i*8 +: 8]; n++; end
      b[n] = T_PORT[15:8]; b[n+1] = T_PORT[7:0]; b[n+2] = seq[15:8]; b[n+3] = seq[7:0];
      b[n+4] = typ ? 8'h01 : 8'h00; b[n+5] = typ ? 8'h7F : T_LOGI; n += 6;
      for (int i = 5; i >= 0; i--) begin b[n] = sec[i*8 +: 8]; n++; end
      for (int i = 3; i >= 0; i--) begin b[n] = ns[i*8 +: 8]; n++; end
      for (int w = 0; w < 16; w++)
         exp_words[w] = (w < NW) ? {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]} : 32'h0;
   endfunction

   task automatic issue(input logic typ, input logic [15:0] seq, output logic ack0, output logic sop0);
      @(negedge clk);
      tx_req = 1'b1; tx_type = typ; tx_seqid = seq;
      @(negedge clk);
      ack0 = tx_ack;
      sop0 = tx_valid & tx_sop;
      tx_req = 1'b0;
   endtask

   // Drives tx_ready from the negedge where W0 is first visible and records every transfer.
   task automatic capture(input int stall_pct, input int sop_stall);
      int left;
      logic [31:0] pd;
      logic pv, ps, pe, pstall;
      logic [1:0] pm;
      left = sop_stall; cap_n = 0; hold_err = 0; flag_err = 0; cap_timeout = 1'b1; pstall = 1'b0;
      pd = '0; pv = 1'b0; ps = 1'b0; pe = 1'b0; pm = '0;
      for (int i = 0; i < 400; i++) begin
         if (i > 0) @(negedge clk);
         if (rtc_inc) rtc_ns = rtc_ns + 32'd1;
         if (cap_n == 0 && left > 0) begin tx_ready = 1'b0; left--; end
         else tx_ready = ($urandom_range(99) >= stall_pct);
         if (pstall && ({tx_data, tx_valid, tx_sop, tx_eop, tx_mod} !== {pd, pv, ps, pe, pm}))
            hold_err++;
         pd = tx_data; pv = tx_valid; ps = tx_sop; pe = tx_eop; pm = tx_mod;
         pstall = tx_valid & ~tx_ready;
         if (tx_valid && tx_ready) begin
            if (tx_sop !== (cap_n == 0) || tx_eop !== (cap_n == NW - 1) || tx_mod !== 2'b00)
               flag_err++;
            if (cap_n == 0) begin cap_sec = rtc_sec; cap_ns = rtc_ns; end
            if (cap_n < 16) cap_words[cap_n] = tx_data;
            cap_n++;
            if (tx_eop === 1'b1 || cap_n >= 16) begin cap_timeout = 1'b0; break; end
         end
      end
      @(negedge clk);
      tx_ready = 1'b0;
      cap_done = tx_done; cap_infor = tx_infor; cap_valid_after = tx_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tx_req = 1'b0; tx_type = 1'b0; tx_seqid = '0; tx_ready = 1'b0;
      rtc_sec = '0; rtc_ns = '0; rtc_inc = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({tx_ack, tx_valid, tx_sop, tx_eop, tx_done} !== 5'b0) begin
         miscompares++; $display("FAIL reset_ctrl: got %b expected 00000", {tx_ack, tx_valid, tx_sop, tx_eop, tx_done});
      end
      vectors++;
      if (tx_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", tx_data); end
      vectors++;
      if (tx_mod !== 2'b00) begin miscompares++; $display("FAIL reset_mod: got %h expected 0", tx_mod); end
      vectors++;
      if (tx_infor !== 52'h0) begin miscompares++; $display("FAIL reset_infor: got %h expected 0", tx_infor); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (tx_valid !== 1'b0 || tx_ack !== 1'b0) begin
         miscompares++; $display("FAIL idle_no_req: valid %b ack %b expected 0 0", tx_valid, tx_ack);
      end
   endtask

   task automatic test_sync_basic();
      logic ack0, sop0;
      rtc_inc = 1'b0; rtc_sec = 48'h0000_6543_21AB; rtc_ns = 32'h0000_1000;
      issue(1'b0, 16'h1234, ack0, sop0);
      vectors++;
      if ({ack0, sop0} !== 2'b11) begin miscompares++; $display("FAIL sync_ack_sop: got %b expected 11", {ack0, sop0}); end
      capture(0, 0);
      build_frame(1'b0, 16'h1234, 48'h0000_6543_21AB, 32'h0000_1000);
      vectors++;
      if (cap_timeout || cap_n != NW) begin miscompares++; $display("FAIL sync_len: got %0d words expected %0d", cap_n, NW); end
      for (int w = 0; w < NW; w++) begin
         vectors++;
         if (cap_words[w] !== exp_words[w]) begin
            miscompares++; $display("FAIL sync_word%0d: got %h expected %h", w, cap_words[w], exp_words[w]);
         end
      end
`ifdef PTP_GEN_VLAN_EN
      vectors++;
      if (cap_words[3] !== {16'h8100, T_TCI}) begin miscompares++; $display("FAIL sync_vlan_w3: got %h expected %h", cap_words[3], {16'h8100, T_TCI}); end
`endif
      vectors++;
      if (cap_words[3+OFF] !== 32'h88F7_0002) begin miscompares++; $display("FAIL sync_ethtype: got %h expected 88f70002", cap_words[3+OFF]); end
      vectors++;
      if (cap_words[11+OFF] !== {16'h1234, 8'h00, T_LOGI}) begin miscompares++; $display("FAIL sync_w11: got %h expected %h", cap_words[11+OFF], {16'h1234, 8'h00, T_LOGI}); end
      vectors++;
      if (cap_words[14+OFF] !== 32'h1000_0000) begin miscompares++; $display("FAIL sync_pad: got %h expected 10000000", cap_words[14+OFF]); end
      vectors++;
      if ({cap_done, cap_valid_after} !== 2'b10 || flag_err != 0) begin
         miscompares++; $display("FAIL sync_done: done %b valid %b flagerr %0d expected 1 0 0", cap_done, cap_valid_after, flag_err);
      end
      vectors++;
      if (cap_infor !== {16'h1234, 4'h0, 32'h0000_1000}) begin miscompares++; $display("FAIL sync_infor: got %h expected %h", cap_infor, {16'h1234, 4'h0, 32'h0000_1000}); end
      @(negedge clk);
      vectors++;
      if ({tx_done, tx_infor} !== 53'h0) begin miscompares++; $display("FAIL done_pulse: done %b infor %h expected 0 0", tx_done, tx_infor); end
   endtask

   task automatic test_delay_req();
      logic ack0, sop0;
      logic [15:0] seq;
      for (int k = 0; k < 2; k++) begin
         seq = 16'($urandom); rtc_inc = 1'b0;
         rtc_sec = {16'($urandom), $urandom}; rtc_ns = $urandom;
         build_frame(1'b1, seq, rtc_sec, rtc_ns);
         issue(1'b1, seq, ack0, sop0);
         capture(0, 0);
         vectors++;
         if (cap_timeout || cap_n != NW || flag_err != 0) begin miscompares++; $display("FAIL dreq_len: got %0d words flagerr %0d expected %0d 0", cap_n, flag_err, NW); end
         for (int w = 0; w < NW; w++) begin
            vectors++;
            if (cap_words[w] !== exp_words[w]) begin miscompares++; $display("FAIL dreq_word%0d: got %h expected %h", w, cap_words[w], exp_words[w]); end
         end
         vectors++;
         if (cap_words[3+OFF] !== 32'h88F7_0102 || cap_words[5+OFF] !== 32'h0) begin
            miscompares++; $display("FAIL dreq_w3w5: got %h %h expected 88f70102 0", cap_words[3+OFF], cap_words[5+OFF]);
         end
         vectors++;
         if (cap_words[11+OFF] !== {seq, 8'h01, 8'h7F}) begin miscompares++; $display("FAIL dreq_w11: got %h expected %h", cap_words[11+OFF], {seq, 8'h01, 8'h7F}); end
         vectors++;
         if (cap_infor !== {seq, 4'h1, rtc_ns}) begin miscompares++; $display("FAIL dreq_infor: got %h expected %h", cap_infor, {seq, 4'h1, rtc_ns}); end
      end
   endtask

   task automatic test_sop_stall();
      logic ack0, sop0;
      logic [31:0] ns0;
      logic [15:0] seq;
      seq = 16'($urandom); ns0 = $urandom; rtc_ns = ns0;
      rtc_sec = {16'($urandom), $urandom}; rtc_inc = 1'b1;
      issue(1'b0, seq, ack0, sop0);
      capture(0, 3);
      rtc_inc = 1'b0;
      build_frame(1'b0, seq, rtc_sec, ns0 + 32'd4);
      vectors++;
      if (hold_err != 0 || flag_err != 0 || cap_timeout) begin
         miscompares++; $display("FAIL stall_hold: holderr %0d flagerr %0d timeout %0d expected 0 0 0", hold_err, flag_err, cap_timeout);
      end
      for (int w = 0; w < NW; w++) begin
         vectors++;
         if (cap_words[w] !== exp_words[w]) begin miscompares++; $display("FAIL stall_word%0d: got %h expected %h", w, cap_words[w], exp_words[w]); end
      end
      vectors++;
      if (cap_infor !== {seq, 4'h0, ns0 + 32'd4}) begin miscompares++; $display("FAIL stall_infor: got %h expected %h", cap_infor, {seq, 4'h0, ns0 + 32'd4}); end
   endtask

   task automatic test_random_stalls();
      logic ack0, sop0, typ;
      logic [15:0] seq;
      for (int k = 0; k < 8; k++) begin
         typ = 1'($urandom); seq = 16'($urandom);
         rtc_sec = {16'($urandom), $urandom}; rtc_ns = $urandom; rtc_inc = 1'b1;
         issue(typ, seq, ack0, sop0);
         capture(45, int'($urandom_range(2)));
         build_frame(typ, seq, cap_sec, cap_ns);
         vectors++;
         if (cap_timeout || cap_n != NW || hold_err != 0 || flag_err != 0) begin
            miscompares++; $display("FAIL rnd%0d_stream: words %0d holderr %0d flagerr %0d expected %0d 0 0", k, cap_n, hold_err, flag_err, NW);
         end
         for (int w = 0; w < NW; w++) begin
            vectors++;
            if (cap_words[w] !== exp_words[w]) begin miscompares++; $display("FAIL rnd%0d_word%0d: got %h expected %h", k, w, cap_words[w], exp_words[w]); end
         end
         vectors++;
         if (cap_infor !== {seq, 3'b000, typ, cap_ns} || cap_done !== 1'b1) begin
            miscompares++; $display("FAIL rnd%0d_infor: got %h done %b expected %h 1", k, cap_infor, cap_done, {seq, 3'b000, typ, cap_ns});
         end
      end
      rtc_inc = 1'b0;
   endtask

   task automatic test_back_to_back();
      localparam int NC = 4 * (NW + 1);
      logic v [NC+3];
      logic s [NC+3];
      logic e [NC+3];
      logic a [NC+3];
      int acks, sops;
      rtc_inc = 1'b0; acks = 0; sops = 0;
      @(negedge clk);
      tx_ready = 1'b1; tx_req = 1'b1; tx_type = 1'b0; tx_seqid = 16'h0042;
      for (int c = 1; c <= NC; c++) begin
         @(negedge clk);
         v[c] = tx_valid; s[c] = tx_sop; e[c] = tx_eop; a[c] = tx_ack;
      end
      tx_req = 1'b0;
      for (int c = 1; c <= NC; c++) begin
         if (a[c] === 1'b1) acks++;
         if (v[c] === 1'b1 && s[c] === 1'b1) sops++;
         vectors++;
         if (a[c] !== (v[c] & s[c])) begin miscompares++; $display("FAIL b2b_ack_at%0d: ack %b expected %b", c, a[c], v[c] & s[c]); end
         if (e[c] === 1'b1 && c + 2 <= NC) begin
            vectors++;
            if ({v[c+1], v[c+2], s[c+2]} !== 3'b011) begin
               miscompares++; $display("FAIL b2b_gap_at%0d: got %b expected 011", c, {v[c+1], v[c+2], s[c+2]});
            end
         end
      end
      vectors++;
      if (acks != 4 || sops != 4) begin miscompares++; $display("FAIL b2b_count: acks %0d sops %0d expected 4 4", acks, sops); end
      for (int i = 0; i < 40 && tx_valid === 1'b1; i++) @(negedge clk);
      vectors++;
      if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: valid %b expected 0", tx_valid); end
      tx_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_midframe();
      logic ack0, sop0;
      logic [15:0] seq;
      seq = 16'($urandom); rtc_inc = 1'b0;
      rtc_sec = {16'($urandom), $urandom}; rtc_ns = $urandom;
      build_frame(1'b1, seq, rtc_sec, rtc_ns);
      issue(1'b1, seq, ack0, sop0);
      tx_ready = 1'b1;
      repeat (7) @(negedge clk);
      vectors++;
      if ({tx_valid, tx_data} !== {1'b1, exp_words[7]}) begin
         miscompares++; $display("FAIL mid_w7: got %b %h expected 1 %h", tx_valid, tx_data, exp_words[7]);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({tx_ack, tx_valid, tx_sop, tx_eop, tx_done, tx_mod, tx_data, tx_infor} !== 91'h0) begin
         miscompares++; $display("FAIL mid_async_clear: valid %b eop %b done %b data %h infor %h expected all 0", tx_valid, tx_eop, tx_done, tx_data, tx_infor);
      end
      tx_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seq = 16'($urandom); rtc_ns = $urandom;
      build_frame(1'b0, seq, rtc_sec, rtc_ns);
      issue(1'b0, seq, ack0, sop0);
      vectors++;
      if ({ack0, sop0} !== 2'b11) begin miscompares++; $display("FAIL mid_restart_ack: got %b expected 11", {ack0, sop0}); end
      capture(20, 0);
      vectors++;
      if (cap_timeout || cap_n != NW || flag_err != 0 || hold_err != 0) begin
         miscompares++; $display("FAIL mid_restart_len: words %0d flagerr %0d holderr %0d expected %0d 0 0", cap_n, flag_err, hold_err, NW);
      end
      for (int w = 0; w < NW; w++) begin
         vectors++;
         if (cap_words[w] !== exp_words[w]) begin miscompares++; $display("FAIL mid_word%0d: got %h expected %h", w, cap_words[w], exp_words[w]); end
      end
   endtask

   initial begin
      test_reset();
      test_sync_basic();
      test_delay_req();
      test_sop_stall();
      test_random_stalls();
      test_back_to_back();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
